// File: rtl/edge_row_packer_pkg.sv
// Shared constants, row entry type and FSM state encoding for the edge row packer.
package edge_pkg;

    localparam int IMG_DIM = 20;
    localparam int VW      = IMG_DIM - 2;
    localparam int IDX_W   = $clog2(IMG_DIM);

    typedef struct packed {
        logic [IMG_DIM-1:0] data;
        logic [IDX_W-1:0]   idx;
    } row_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_TOP,
        COLLECT,
        EMIT_BOTTOM,
        DONE
    } state_t;

endpackage

// File: rtl/edge_row_packer_if.sv
// Valid/ready row stream from the packer to its consumer.
interface edge_row_packer_if;
    import edge_pkg::*;

    logic [IMG_DIM-1:0] row_data;
    logic [IDX_W-1:0]   row_idx;
    logic               row_valid;
    logic               row_ready;

    modport master (output row_data, output row_idx, output row_valid, input row_ready);
    modport slave  (input row_data, input row_idx, input row_valid, output row_ready);

endinterface

// File: rtl/edge_row_packer_fifo.sv
// First-word fall-through FIFO of row entries; head reads zero while empty.
module row_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic valid,
    output logic full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign valid     = (r_count != '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop && valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/edge_row_packer.sv
// Packs the serial interior edge bits into bordered row words and queues them,
// adding all-zero top and bottom rows around each frame.
module edge_row_packer
    import edge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      edge_in,
    input  logic                      edge_valid,
    edge_row_packer_if.master         row_if,
    output logic                      frame_done,
    output logic                      overflow,
    output logic                      busy
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_col;
    logic [IDX_W-1:0]   r_row;
    logic [IMG_DIM-1:0] r_shift;
    logic               r_frame_done;
    logic               r_overflow;

    logic               w_push;
    row_entry_t         w_entry;
    row_entry_t         w_head;
    logic [IMG_DIM-1:0] w_row_word;
    logic               w_full;
    logic               w_fifo_valid;
    logic               w_pop;
    logic               w_last_bit;
    logic               w_abort;

    assign w_pop      = w_fifo_valid && row_if.row_ready;
    assign w_last_bit = (r_state == COLLECT) && edge_valid && (r_col == IDX_W'(VW - 1));
    assign w_abort    = frame_start && (r_state != IDLE);

    // The completing bit bypasses the shift register so the word can be pushed on its own edge.
    always_comb begin
        w_row_word                      = r_shift;
        w_row_word[r_col + IDX_W'(1)]   = edge_in;
        w_row_word[0]                   = 1'b0;
        w_row_word[IMG_DIM-1]           = 1'b0;
        w_push                          = 1'b0;
        w_entry                         = '0;
        case (r_state)
            EMIT_TOP: begin
                w_push = !w_full;
            end
            COLLECT: begin
                w_push       = w_last_bit;
                w_entry.data = w_row_word;
                w_entry.idx  = r_row + IDX_W'(1);
            end
            EMIT_BOTTOM: begin
                w_push      = !w_full;
                w_entry.idx = IDX_W'(IMG_DIM - 1);
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (row_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_abort),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (row_if.row_ready),
        .head      (w_head),
        .valid     (w_fifo_valid),
        .full      (w_full)
    );

    // The edge source cannot be stalled, so counters advance even when a full FIFO drops the row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_shift      <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (frame_start) begin
                r_state    <= EMIT_TOP;
                r_col      <= '0;
                r_row      <= '0;
                r_shift    <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    EMIT_TOP: begin
                        if (!w_full) begin
                            r_state <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (edge_valid) begin
                            r_shift[r_col + IDX_W'(1)] <= edge_in;
                            if (w_last_bit) begin
                                r_col <= '0;
                                r_row <= r_row + IDX_W'(1);
                                if (w_full && !w_pop) begin
                                    r_overflow <= 1'b1;
                                end
                                if (r_row == IDX_W'(VW - 1)) begin
                                    r_state <= EMIT_BOTTOM;
                                end
                            end else begin
                                r_col <= r_col + IDX_W'(1);
                            end
                        end
                    end
                    EMIT_BOTTOM: begin
                        if (!w_full) begin
                            r_state <= DONE;
                        end
                    end
                    DONE: begin
                        if (!w_fifo_valid) begin
                            r_frame_done <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign row_if.row_data  = w_head.data;
    assign row_if.row_idx   = w_head.idx;
    assign row_if.row_valid = w_fifo_valid;
    assign frame_done       = r_frame_done;
    assign overflow         = r_overflow;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_edge_row_packer.sv
// Scenario bench for edge_row_packer: scoreboarded row stream plus direct control checks.
module tb_edge_row_packer;
    import edge_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic edge_in;
    logic edge_valid;
    logic frame_done;
    logic overflow;
    logic busy;

    int errors    = 0;
    int checks    = 0;
    int doneCount = 0;
    row_entry_t sbQ[$];

    edge_row_packer_if rowIf();

    edge_row_packer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .edge_in     (edge_in),
        .edge_valid  (edge_valid),
        .row_if      (rowIf),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected the bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic row_entry_t mkEntry(input logic [IMG_DIM-1:0] d, input int r);
        row_entry_t e;
        e.data = d;
        e.idx  = IDX_W'(r);
        return e;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Compares every accepted head against the oldest expected row.
    task automatic monitorLoop();
        row_entry_t exp;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) doneCount++;
            if (rowIf.row_valid === 1'b1 && rowIf.row_ready === 1'b1) begin
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got idx=%0d data=%h, expected no row",
                             rowIf.row_idx, rowIf.row_data);
                end else begin
                    exp = sbQ.pop_front();
                    if (rowIf.row_data !== exp.data || rowIf.row_idx !== exp.idx) begin
                        errors++;
                        $display("[TB] FAIL sb_row: got idx=%0d data=%h, expected idx=%0d data=%h",
                                 rowIf.row_idx, rowIf.row_data, exp.idx, exp.data);
                    end
                end
            end
        end
    endtask

    task automatic sendRow(input int r, input logic [VW-1:0] bits, input bit keep, input bit popLast);
        logic [IMG_DIM-1:0] w = '0;
        for (int c = 0; c < VW; c++) w[c+1] = bits[c];
        for (int c = 0; c < VW; c++) begin
            edge_in    = bits[c];
            edge_valid = 1'b1;
            if (c == VW - 1) begin
                if (keep) sbQ.push_back(mkEntry(w, r));
                if (popLast) rowIf.row_ready = 1'b1;
            end
            stepCycle();
            if (c == VW - 1 && popLast) rowIf.row_ready = 1'b0;
        end
        edge_valid = 1'b0;
        edge_in    = 1'b0;
    endtask

    function automatic logic [VW-1:0] randBits();
        logic [31:0] t;
        t = $urandom;
        return t[VW-1:0];
    endfunction

    task automatic applyStimulusFrameStart();
        frame_start = 1'b1;
        sbQ.push_back(mkEntry('0, 0));
        stepCycle();
        frame_start = 1'b0;
        stepCycle();
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_start = 1'b0; edge_in = 1'b0; edge_valid = 1'b0;
        rowIf.row_ready = 1'b0;
        stepCycle(); stepCycle();
        reset = 1'b1;
        stepCycle();
        checks++; if (rowIf.row_data !== '0) begin errors++; $display("[TB] FAIL rst_data: got %h, expected 0", rowIf.row_data); end
        checks++; if (rowIf.row_idx !== '0) begin errors++; $display("[TB] FAIL rst_idx: got %0d, expected 0", rowIf.row_idx); end
        checks++; if (rowIf.row_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b, expected 0", rowIf.row_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b, expected 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf: got %b, expected 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_full_frame();
        logic [VW-1:0] bits;
        int g = 0;
        int d0;
        rowIf.row_ready = 1'b1;
        d0 = doneCount;
        frame_start = 1'b1;
        sbQ.push_back(mkEntry('0, 0));
        stepCycle();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ff_busy: got %b, expected 1", busy); end
        checks++; if (rowIf.row_valid !== 1'b0) begin errors++; $display("[TB] FAIL ff_valid_n1: got %b, expected 0", rowIf.row_valid); end
        frame_start = 1'b0;
        stepCycle();
        checks++; if (rowIf.row_valid !== 1'b1 || rowIf.row_idx !== '0) begin
            errors++; $display("[TB] FAIL ff_top_head: got valid=%b idx=%0d, expected valid=1 idx=0", rowIf.row_valid, rowIf.row_idx); end
        for (int r = 1; r <= VW; r++) begin
            for (int c = 0; c < VW; c++) begin
                bits[c] = (g % 2 == 0);
                g++;
            end
            sendRow(r, bits, 1'b1, 1'b0);
            if (r == 1) begin
                checks++; if (rowIf.row_valid !== 1'b1 || rowIf.row_idx !== IDX_W'(1)) begin
                    errors++; $display("[TB] FAIL ff_row1_latency: got valid=%b idx=%0d, expected valid=1 idx=1", rowIf.row_valid, rowIf.row_idx); end
            end
        end
        sbQ.push_back(mkEntry('0, IMG_DIM - 1));
        for (int i = 0; i < 100 && doneCount == d0; i++) stepCycle();
        stepCycle(); stepCycle(); stepCycle();
        checks++; if (doneCount != d0 + 1) begin errors++; $display("[TB] FAIL ff_done_pulses: got %0d, expected 1", doneCount - d0); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ff_ovf: got %b, expected 0", overflow); end
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL ff_sb_left: got %0d rows pending, expected 0", sbQ.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ff_idle: got busy=%b, expected 0", busy); end
    endtask

    task automatic test_overflow();
        int d0;
        rowIf.row_ready = 1'b0;
        d0 = doneCount;
        applyStimulusFrameStart();
        for (int r = 1; r <= VW; r++) begin
            sendRow(r, randBits(), (r <= 3), 1'b0);
            if (r == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ov_before: got %b, expected 0", overflow); end
            end
            if (r == 4) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ov_set: got %b, expected 1", overflow); end
            end
        end
        sbQ.push_back(mkEntry('0, IMG_DIM - 1));
        for (int i = 0; i < 5; i++) stepCycle();
        checks++; if (busy !== 1'b1 || doneCount != d0) begin
            errors++; $display("[TB] FAIL ov_bottom_wait: got busy=%b done=%0d, expected busy=1 done=0", busy, doneCount - d0); end
        checks++; if (rowIf.row_valid !== 1'b1 || rowIf.row_idx !== '0) begin
            errors++; $display("[TB] FAIL ov_head: got valid=%b idx=%0d, expected valid=1 idx=0", rowIf.row_valid, rowIf.row_idx); end
        rowIf.row_ready = 1'b1;
        for (int i = 0; i < 100 && doneCount == d0; i++) stepCycle();
        checks++; if (doneCount != d0 + 1) begin errors++; $display("[TB] FAIL ov_done: got %0d pulses, expected 1", doneCount - d0); end
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL ov_sb_left: got %0d rows pending, expected 0", sbQ.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ov_sticky: got %b, expected 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        int d0;
        rowIf.row_ready = 1'b0;
        d0 = doneCount;
        frame_start = 1'b1;
        sbQ.push_back(mkEntry('0, 0));
        stepCycle();
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pp_ovf_clear: got %b, expected 0", overflow); end
        frame_start = 1'b0;
        stepCycle();
        for (int r = 1; r <= 3; r++) sendRow(r, randBits(), 1'b1, 1'b0);
        sendRow(4, randBits(), 1'b1, 1'b1);
        checks++; if (rowIf.row_valid !== 1'b1 || rowIf.row_idx !== IDX_W'(1)) begin
            errors++; $display("[TB] FAIL pp_head: got valid=%b idx=%0d, expected valid=1 idx=1", rowIf.row_valid, rowIf.row_idx); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pp_ovf: got %b, expected 0", overflow); end
        rowIf.row_ready = 1'b1;
        for (int r = 5; r <= VW; r++) sendRow(r, randBits(), 1'b1, 1'b0);
        sbQ.push_back(mkEntry('0, IMG_DIM - 1));
        for (int i = 0; i < 100 && doneCount == d0; i++) stepCycle();
        checks++; if (doneCount != d0 + 1) begin errors++; $display("[TB] FAIL pp_done: got %0d pulses, expected 1", doneCount - d0); end
        checks++; if (overflow !== 1'b0 || sbQ.size() != 0) begin
            errors++; $display("[TB] FAIL pp_end: got ovf=%b pending=%0d, expected ovf=0 pending=0", overflow, sbQ.size()); end
    endtask

    task automatic test_abort();
        int d0;
        logic [VW-1:0] bits;
        rowIf.row_ready = 1'b0;
        applyStimulusFrameStart();
        for (int r = 1; r <= 6; r++) sendRow(r, randBits(), (r <= 3), 1'b0);
        bits = randBits();
        for (int c = 0; c < 5; c++) begin
            edge_in = bits[c]; edge_valid = 1'b1;
            stepCycle();
        end
        edge_valid = 1'b0;
        sbQ.delete();
        d0 = doneCount;
        frame_start = 1'b1;
        sbQ.push_back(mkEntry('0, 0));
        stepCycle();
        checks++; if (rowIf.row_valid !== 1'b0) begin errors++; $display("[TB] FAIL ab_flush: got valid=%b, expected 0", rowIf.row_valid); end
        checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL ab_ctrl: got ovf=%b busy=%b, expected ovf=0 busy=1", overflow, busy); end
        frame_start = 1'b0;
        stepCycle();
        checks++; if (rowIf.row_valid !== 1'b1 || rowIf.row_idx !== '0) begin
            errors++; $display("[TB] FAIL ab_top: got valid=%b idx=%0d, expected valid=1 idx=0", rowIf.row_valid, rowIf.row_idx); end
        rowIf.row_ready = 1'b1;
        for (int r = 1; r <= VW; r++) sendRow(r, randBits(), 1'b1, 1'b0);
        sbQ.push_back(mkEntry('0, IMG_DIM - 1));
        for (int i = 0; i < 100 && doneCount == d0; i++) stepCycle();
        checks++; if (doneCount != d0 + 1 || sbQ.size() != 0) begin
            errors++; $display("[TB] FAIL ab_restart: got done=%0d pending=%0d, expected done=1 pending=0", doneCount - d0, sbQ.size()); end
    endtask

    task automatic test_reset_midframe();
        int d0;
        int badValid = 0;
        logic [VW-1:0] bits;
        rowIf.row_ready = 1'b1;
        applyStimulusFrameStart();
        for (int r = 1; r <= 2; r++) sendRow(r, randBits(), 1'b1, 1'b0);
        bits = randBits();
        for (int c = 0; c < 7; c++) begin
            edge_in = bits[c]; edge_valid = 1'b1;
            stepCycle();
        end
        edge_valid = 1'b0;
        reset = 1'b0;
        stepCycle();
        reset = 1'b1;
        sbQ.delete();
        checks++; if (rowIf.row_valid !== 1'b0 || rowIf.row_data !== '0 || rowIf.row_idx !== '0) begin
            errors++; $display("[TB] FAIL mr_row: got valid=%b idx=%0d data=%h, expected all 0", rowIf.row_valid, rowIf.row_idx, rowIf.row_data); end
        checks++; if (busy !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL mr_ctrl: got busy=%b ovf=%b done=%b, expected 0 0 0", busy, overflow, frame_done); end
        d0 = doneCount;
        for (int i = 0; i < 40; i++) begin
            edge_in = 1'b1; edge_valid = 1'b1;
            stepCycle();
            if (rowIf.row_valid !== 1'b0 || busy !== 1'b0) badValid++;
        end
        edge_valid = 1'b0;
        checks++; if (badValid != 0 || doneCount != d0) begin
            errors++; $display("[TB] FAIL mr_ignore: got %0d active cycles, %0d done, expected 0 and 0", badValid, doneCount - d0); end
    endtask

    initial begin
        fork
            monitorLoop();
        join_none
        test_reset();
        test_full_frame();
        test_overflow();
        test_push_pop_full();
        test_abort();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
